// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 valid/ready stream mux with round-robin or forced select and a registered output.
// Optional packet lock (grant held until Last) is enabled by defining STREAM_MUX_LOCK_EN.
module stream_mux_rr #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_CH = 4,
  localparam int CH_W = $clog2(NUM_CH)
) (
  input  logic                         MUX_CLOCK_50,
  input  logic                         MUX_RESET_InHigh,
  input  logic [NUM_CH*DATA_WIDTH-1:0] MUX_Data_InBUS,
  input  logic [NUM_CH-1:0]            MUX_Valid_InBUS,
  output logic [NUM_CH-1:0]            MUX_Ready_OutBUS,
  input  logic                         MUX_Mode_In,
  input  logic [CH_W-1:0]              MUX_Sel_InBUS,
`ifdef STREAM_MUX_LOCK_EN
  input  logic [NUM_CH-1:0]            MUX_Last_InBUS,
  output logic                         MUX_Last_Out,
`endif
  output logic [DATA_WIDTH-1:0]        MUX_Data_OutBUS,
  output logic                         MUX_Valid_Out,
  input  logic                         MUX_Ready_In,
  output logic [CH_W-1:0]              MUX_Ch_OutBUS
);

  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] arb_gnt;
  logic            arb_vld;
  logic [CH_W-1:0] gnt;
  logic            gnt_vld;
  logic [CH_W-1:0] gnt_nxt;
  logic            sel_ok;
  logic            free;
  logic            xfer;
  logic            pkt_end;

`ifdef STREAM_MUX_LOCK_EN
  logic            lock_q;
  logic [CH_W-1:0] lock_ch_q;
`endif

  assign free = !MUX_Valid_Out || MUX_Ready_In;

  // Non-power-of-two channel counts leave select codes that map to no channel.
  if ((1 << CH_W) == NUM_CH) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_part
    assign sel_ok = MUX_Sel_InBUS < CH_W'(NUM_CH);
  end

  always_comb begin
    int idx;
    idx = 0;
    arb_gnt = '0;
    arb_vld = 1'b0;
    if (MUX_Mode_In) begin
      arb_gnt = MUX_Sel_InBUS;
      arb_vld = sel_ok && MUX_Valid_InBUS[MUX_Sel_InBUS];
    end else begin
      // Walk downward so the channel closest to ptr is the last writer.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        idx = (int'(ptr_q) + i) % NUM_CH;
        if (MUX_Valid_InBUS[idx]) begin
          arb_vld = 1'b1;
          arb_gnt = CH_W'(idx);
        end
      end
    end
  end

`ifdef STREAM_MUX_LOCK_EN
  always_comb begin
    gnt     = arb_gnt;
    gnt_vld = arb_vld;
    if (lock_q) begin
      gnt     = lock_ch_q;
      gnt_vld = MUX_Valid_InBUS[lock_ch_q];
    end
  end

  assign pkt_end = MUX_Last_InBUS[gnt];
`else
  assign gnt     = arb_gnt;
  assign gnt_vld = arb_vld;
  assign pkt_end = 1'b1;
`endif

  always_comb begin
    MUX_Ready_OutBUS = '0;
    if (!MUX_RESET_InHigh && free && gnt_vld) begin
      MUX_Ready_OutBUS[gnt] = 1'b1;
    end
  end

  assign xfer = free && gnt_vld;

  assign gnt_nxt = (int'(gnt) == NUM_CH - 1) ? '0 : gnt + 1'b1;

  always_ff @(posedge MUX_CLOCK_50 or posedge MUX_RESET_InHigh) begin
    if (MUX_RESET_InHigh) begin
      MUX_Valid_Out   <= 1'b0;
      MUX_Data_OutBUS <= '0;
      MUX_Ch_OutBUS   <= '0;
      ptr_q           <= '0;
`ifdef STREAM_MUX_LOCK_EN
      MUX_Last_Out    <= 1'b0;
      lock_q          <= 1'b0;
      lock_ch_q       <= '0;
`endif
    end else begin
      if (xfer) begin
        MUX_Valid_Out   <= 1'b1;
        MUX_Data_OutBUS <= MUX_Data_InBUS[int'(gnt)*DATA_WIDTH +: DATA_WIDTH];
        MUX_Ch_OutBUS   <= gnt;
        if (!MUX_Mode_In && pkt_end) begin
          ptr_q <= gnt_nxt;
        end
`ifdef STREAM_MUX_LOCK_EN
        MUX_Last_Out <= pkt_end;
        lock_q       <= !pkt_end;
        lock_ch_q    <= gnt;
`endif
      end else if (MUX_Ready_In) begin
        MUX_Valid_Out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed + randomized checks of stream_mux_rr against a queue-based model.
// Define STREAM_MUX_LOCK_EN for both files to exercise the packet lock.
module tb_stream_mux_rr;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] din;
  logic [N-1:0]    vin;
  logic [N-1:0]    rdy;
  logic            mode;
  logic [1:0]      sel;
  logic [DW-1:0]   dout;
  logic            vout;
  logic            rin;
  logic [1:0]      chout;
  logic [N-1:0]    lin;
`ifdef STREAM_MUX_LOCK_EN
  logic            lout;
`endif

  int checks = 0;
  int passed = 0;

  bit            m_v;
  logic [DW-1:0] m_d;
  int            m_ch;
  int            m_ptr;
  bit            m_lock;
  int            m_lk;
  bit            m_last;

  int            sb_ch[$];
  logic [DW-1:0] sb_d[$];
  int            deliv[$];

  stream_mux_rr #(.DATA_WIDTH(DW), .NUM_CH(N)) dut (
    .MUX_CLOCK_50     (clk),
    .MUX_RESET_InHigh (rst),
    .MUX_Data_InBUS   (din),
    .MUX_Valid_InBUS  (vin),
    .MUX_Ready_OutBUS (rdy),
    .MUX_Mode_In      (mode),
    .MUX_Sel_InBUS    (sel),
`ifdef STREAM_MUX_LOCK_EN
    .MUX_Last_InBUS   (lin),
    .MUX_Last_Out     (lout),
`endif
    .MUX_Data_OutBUS  (dout),
    .MUX_Valid_Out    (vout),
    .MUX_Ready_In     (rin),
    .MUX_Ch_OutBUS    (chout)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model grant: locked channel, else forced sel, else first valid from ptr.
  function automatic void m_grant(output bit gv, output int g);
    gv = 1'b0;
    g  = 0;
    if (m_lock) begin
      g  = m_lk;
      gv = vin[m_lk];
    end else if (mode) begin
      g  = int'(sel);
      gv = (g < N) && vin[g];
    end else begin
      for (int i = 0; i < N; i++) begin
        if (vin[(m_ptr + i) % N]) begin
          gv = 1'b1;
          g  = (m_ptr + i) % N;
          break;
        end
      end
    end
  endfunction

  // One clock: compare at mid-cycle, then advance the model across the edge.
  task automatic cyc();
    bit            gv;
    int            g;
    bit            free;
    bit            lst;
    logic [N-1:0]  er;
    #1;
    m_grant(gv, g);
    free = !m_v || rin;
    er = '0;
    if (gv && free) er[g] = 1'b1;
    chk("ready_out", rdy, er);
    chk("valid_out", vout, m_v);
    if (m_v) begin
      chk("data_out", dout, m_d);
      chk("ch_out", chout, m_ch);
`ifdef STREAM_MUX_LOCK_EN
      chk("last_out", lout, m_last);
`endif
    end
    if (vout === 1'b1 && rin) begin
      if (sb_d.size() == 0) begin
        checks++;
        $display("FAIL sb_extra_beat: got ch %0d data %0h expected none", chout, dout);
      end else begin
        chk("sb_data", dout, sb_d.pop_front());
        chk("sb_ch", chout, sb_ch.pop_front());
        deliv.push_back(int'(chout));
      end
    end
    @(posedge clk);
    lst = 1'b1;
`ifdef STREAM_MUX_LOCK_EN
    lst = lin[g];
`endif
    if (gv && free) begin
      m_v  = 1'b1;
      m_d  = din[g*DW +: DW];
      m_ch = g;
      m_last = lst;
      sb_d.push_back(m_d);
      sb_ch.push_back(g);
`ifdef STREAM_MUX_LOCK_EN
      m_lock = !lst;
      m_lk   = g;
`endif
      if (!mode && lst) m_ptr = (g + 1) % N;
    end else if (rin) begin
      m_v = 1'b0;
    end
    @(negedge clk);
  endtask

  // Called away from a rising edge; reset effect is checked before any edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid_out", vout, 1'b0);
    chk("rst_data_out", dout, '0);
    chk("rst_ch_out", chout, '0);
    chk("rst_ready_out", rdy, '0);
    m_v = 1'b0; m_d = '0; m_ch = 0; m_ptr = 0;
    m_lock = 1'b0; m_lk = 0; m_last = 1'b0;
    sb_d.delete();
    sb_ch.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n0;
    rst = 1'b1; vin = '0; din = '0; rin = 1'b0;
    mode = 1'b0; sel = '0; lin = '1;
    @(negedge clk);
    vin = '1;
    do_reset();

    // All channels valid: strict rotation A0..A3, A0.
    for (int k = 0; k < N; k++) din[k*DW +: DW] = 32'hA0 + k;
    vin = 4'hF; rin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_data", dout, 32'hA0 + (i % 4));
      chk("rr_ch", chout, i % 4);
    end

    // Single channel under a 5-cycle stall.
    vin = '0;
    cyc();
    chk("drain_valid", vout, 1'b0);
    vin = 4'b0100; din[2*DW +: DW] = 32'h55; rin = 1'b0;
    n0 = deliv.size();
    cyc();
    chk("stall_vout", vout, 1'b1);
    chk("stall_data0", dout, 32'h55);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_ready", rdy, 4'b0000);
      chk("stall_data", dout, 32'h55);
    end
    vin = '0; rin = 1'b1;
    cyc();
    chk("stall_after_vout", vout, 1'b0);
    chk("stall_one_beat", deliv.size() - n0, 1);

    // Forced select of ch3 with ch1 competing.
    mode = 1'b1; sel = 2'd3; vin = 4'b1010;
    din[1*DW +: DW] = 32'h11; din[3*DW +: DW] = 32'h33;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("frc_rdy1", rdy[1], 1'b0);
      chk("frc_ch", chout, 2'd3);
      chk("frc_data", dout, 32'h33);
    end
    vin = 4'b0010;
    cyc();
    cyc();
    chk("frc_idle_vout", vout, 1'b0);
    chk("frc_idle_rdy", rdy, 4'b0000);

    // Reset while a beat is held and ch1 waits.
    mode = 1'b0; vin = 4'b0011; rin = 1'b0;
    din[0 +: DW] = 32'hC0; din[DW +: DW] = 32'hC1;
    cyc();
    chk("mid_vout", vout, 1'b1);
    do_reset();
    vin = 4'b0110; rin = 1'b1;
    cyc();
    chk("post_rst_ch", chout, 2'd1);
    chk("post_rst_data", dout, din[DW +: DW]);

    // Ready toggling with every channel valid keeps strict rotation.
    vin = 4'hF;
    n0 = deliv.size();
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < N; k++) din[k*DW +: DW] = $urandom;
      rin = (i % 2) == 0;
      cyc();
    end
    for (int j = n0 + 1; j < deliv.size(); j++) begin
      chk("toggle_rr_order", deliv[j], (deliv[j-1] + 1) % N);
    end

    // Random traffic, modes and selects.
    for (int i = 0; i < 600; i++) begin
      vin = N'($urandom);
      for (int k = 0; k < N; k++) din[k*DW +: DW] = $urandom;
      rin = $urandom_range(0, 3) != 0;
      mode = $urandom_range(0, 4) == 0;
      sel = 2'($urandom);
`ifdef STREAM_MUX_LOCK_EN
      lin = N'($urandom);
`endif
      cyc();
    end

`ifdef STREAM_MUX_LOCK_EN
    // ch0 sends a 3-beat packet while ch1 waits.
    vin = '0; rin = 1'b1; mode = 1'b0; lin = '1;
    cyc();
    do_reset();
    vin = 4'b0011; lin = 4'b1110;
    cyc();
    chk("lock_b1_ch", chout, 2'd0);
    chk("lock_b1_rdy1", rdy[1], 1'b0);
    cyc();
    chk("lock_b2_ch", chout, 2'd0);
    chk("lock_b2_rdy1", rdy[1], 1'b0);
    lin = 4'b1111;
    cyc();
    chk("lock_b3_ch", chout, 2'd0);
    chk("lock_b3_last", lout, 1'b1);
    chk("lock_rel_rdy", rdy, 4'b0010);
    cyc();
    chk("lock_next_ch", chout, 2'd1);
`endif

    vin = '0; rin = 1'b1;
    for (int i = 0; i < 3; i++) cyc();
    chk("sb_empty", sb_d.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
